// File: rtl/ps2_rx_pkg.sv
// rtl/ps2_rx_pkg.sv - shared PS/2 receiver state encoding, frame size and scan codes
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = 8;

  // Scan codes shared with the key-decode FSM
  localparam logic [7:0] BREAK_CODE  = 8'hF0;
  localparam logic [7:0] LEFT_SHIFT  = 8'h12;
  localparam logic [7:0] RIGHT_SHIFT = 8'h59;
  localparam logic [7:0] CAPS_LOCK   = 8'h58;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF sync of PS/2 lines, glitch filter on clock, falling-edge event
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_data,
  output logic o_fe
);

  localparam int CW = $clog2(FILTER_LEN);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [CW-1:0] run_cnt;
  logic          clk_filt;
  logic          fe;

  // run_cnt counts consecutive synchronised samples that disagree with clk_filt
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      run_cnt   <= '0;
      clk_filt  <= 1'b1;
      fe        <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], i_ps2_clk};
      data_sync <= {data_sync[0], i_ps2_data};
      fe        <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        run_cnt  <= '0;
        clk_filt <= clk_sync[1];
        fe       <= clk_filt;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  assign o_data = data_sync[1];
  assign o_fe   = fe;

endmodule

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver feeding the key-decode FSM
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte_code,
  output logic       o_update_key,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic fe;
  logic data_s;

  ps2_state_t state_q, state_d;
  logic [PS2_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    byte_q, byte_d;
  logic          upd_q, upd_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          timeout;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_ps2_clk  (i_ps2_clk),
    .i_ps2_data (i_ps2_data),
    .o_data     (data_s),
    .o_fe       (fe)
  );

  // Aborts at TIMEOUT_CYCLES-1 so the counter never wraps
  assign timeout = (state_q != ST_IDLE) && (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      to_q      <= '0;
      byte_q    <= 8'h00;
      upd_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      to_q      <= to_d;
      byte_q    <= byte_d;
      upd_q     <= upd_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    byte_d    = byte_q;
    upd_d     = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    to_d      = (fe || state_q == ST_IDLE) ? '0 : to_q + 1'b1;

    // An edge takes priority over a coincident timeout
    if (fe) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          shreg_d   = {data_s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_d = data_s;
          state_d  = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (!data_s) begin
            ferr_d = 1'b1;
          end else if (odd_parity_ok(shreg_q, parity_q)) begin
            byte_d = shreg_q;
            upd_d  = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      ferr_d  = 1'b1;
    end
  end

  assign o_byte_code  = byte_q;
  assign o_update_key = upd_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - directed self-checking bench for ps2_rx
`timescale 1ns/1ps
module tb_ps2_rx;
  import ps2_rx_pkg::*;

  localparam int FLEN = 8;
  localparam int TOUT = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] byte_code;
  logic       update_key, parity_err, frame_err, busy;

  ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ps2_clk    (ps2_clk),
    .i_ps2_data   (ps2_data),
    .o_byte_code  (byte_code),
    .o_update_key (update_key),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0, fe_cyc = 0, fe_cnt = 0;
  int upd_cnt = 0, perr_cnt = 0, ferr_cnt = 0;
  int last_lat = -1, run = 0, max_run = 0;
  logic [7:0] upd_bytes [0:31];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (dut.fe) begin
      fe_cyc <= cyc;
      fe_cnt <= fe_cnt + 1;
    end
    if (update_key) begin
      upd_bytes[upd_cnt % 32] <= byte_code;
      upd_cnt  <= upd_cnt + 1;
      last_lat <= cyc - fe_cyc;
      run      <= run + 1;
      if (run + 1 > max_run) max_run <= run + 1;
    end else begin
      run <= 0;
    end
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        wait_cyc(12);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s, input int glitch_at);
    send_bits({s, p, b, 1'b0}, 11, glitch_at);
    ps2_data = 1'b1;
  endtask

  int u0, p0, f0, e0;

  task automatic snap();
    u0 = upd_cnt; p0 = perr_cnt; f0 = ferr_cnt; e0 = fe_cnt;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    wait_cyc(3);
    chk("rst_byte", byte_code, 8'h00);
    chk("rst_upd", update_key, 1'b0);
    chk("rst_perr", parity_err, 1'b0);
    chk("rst_ferr", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(10);

    // 0x1C, parity 0: clean decode, 1-cycle strobe one cycle after stop edge
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    wait_cyc(30);
    chk("f1c_upd", upd_cnt - u0, 1);
    chk("f1c_byte", byte_code, 8'h1C);
    chk("f1c_lat", last_lat, 1);
    chk("f1c_width", max_run, 1);
    chk("f1c_perr", perr_cnt - p0, 0);
    chk("f1c_ferr", ferr_cnt - f0, 0);
    chk("f1c_fe", fe_cnt - e0, PS2_FRAME_BITS);
    chk("f1c_busy", busy, 1'b0);

    // Back-to-back break code then 0x1C
    snap();
    send_frame(BREAK_CODE, 1'b1, 1'b1, -1);
    send_frame(8'h1C, 1'b0, 1'b1, -1);
    wait_cyc(30);
    chk("b2b_upd", upd_cnt - u0, 2);
    chk("b2b_first", upd_bytes[u0 % 32], 8'hF0);
    chk("b2b_second", upd_bytes[(u0 + 1) % 32], 8'h1C);
    chk("b2b_lat", last_lat, 1);

    // Bad parity: error pulse only, byte held
    snap();
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    wait_cyc(30);
    chk("par_perr", perr_cnt - p0, 1);
    chk("par_upd", upd_cnt - u0, 0);
    chk("par_ferr", ferr_cnt - f0, 0);
    chk("par_byte", byte_code, 8'h1C);

    // Stop bit 0 with good parity: frame error only
    snap();
    send_frame(LEFT_SHIFT, 1'b1, 1'b0, -1);
    wait_cyc(30);
    chk("stop_ferr", ferr_cnt - f0, 1);
    chk("stop_upd", upd_cnt - u0, 0);
    chk("stop_perr", perr_cnt - p0, 0);
    chk("stop_byte", byte_code, 8'h1C);

    // Partial frame: start + 4 data bits then clock held high
    snap();
    send_bits({2'b11, 8'h35, 1'b0}, 5, -1);
    ps2_data = 1'b1;
    wait_cyc(200);
    chk("to_busy_mid", busy, 1'b1);
    chk("to_early", ferr_cnt - f0, 0);
    wait_cyc(300);
    chk("to_ferr", ferr_cnt - f0, 1);
    chk("to_busy_end", busy, 1'b0);
    chk("to_upd", upd_cnt - u0, 0);

    snap();
    send_frame(LEFT_SHIFT, 1'b1, 1'b1, -1);
    wait_cyc(30);
    chk("post_to_upd", upd_cnt - u0, 1);
    chk("post_to_byte", byte_code, 8'h12);

    // 3-cycle clock glitch in idle, then inside a frame
    snap();
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    chk("gl_idle_fe", fe_cnt - e0, 0);
    chk("gl_idle_busy", busy, 1'b0);
    snap();
    send_frame(CAPS_LOCK, 1'b0, 1'b1, 4);
    wait_cyc(30);
    chk("gl_frame_fe", fe_cnt - e0, PS2_FRAME_BITS);
    chk("gl_frame_upd", upd_cnt - u0, 1);
    chk("gl_frame_byte", byte_code, 8'h58);
    chk("gl_frame_err", (perr_cnt - p0) + (ferr_cnt - f0), 0);

    // Reset after data bit 4: immediate reset values, no pulses, then a clean frame
    snap();
    send_bits({2'b11, 8'hA5, 1'b0}, 5, -1);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_byte", byte_code, 8'h00);
    chk("mrst_pulses", {update_key, parity_err, frame_err}, 3'b000);
    ps2_data = 1'b1;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(TOUT + 100);
    chk("mrst_no_upd", upd_cnt - u0, 0);
    chk("mrst_no_err", (perr_cnt - p0) + (ferr_cnt - f0), 0);
    snap();
    send_frame(RIGHT_SHIFT, 1'b1, 1'b1, -1);
    wait_cyc(30);
    chk("mrst_next_upd", upd_cnt - u0, 1);
    chk("mrst_next_byte", byte_code, 8'h59);
    chk("final_width", max_run, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
